pcc_seq: RTL and testbench
==========================

# pcc_seq

Multi-cycle popcount-compare sequencer for wide pos/neg vectors. It accepts one pos vector and one neg vector over a valid/ready handshake. It then streams them one slice per cycle through a 2-pos/4-neg popcount slice, accumulates both counts, and returns `pos_count >= neg_count` over a second valid/ready handshake. It sits between the feature-vector source and the downstream classifier logic, and it time-shares a single narrow popcount slice.

## Interface
- `CHUNKS`, default 4: number of slices per vector. Pos width is 2*CHUNKS, neg width is 4*CHUNKS; must be ≥1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  request valid.
- `in_ready`  out  1  request accepted when high with `in_valid`.
- `in_pos`  in  2*CHUNKS  positive bit vector.
- `in_neg`  in  4*CHUNKS  negative bit vector.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumed when high with `out_valid`.
- `out_result`  out  1  1 iff pos count ≥ neg count.
- `out_pos_cnt`  out  clog2(2*CHUNKS+1)  accumulated pos count.
- `out_neg_cnt`  out  clog2(4*CHUNKS+1)  accumulated neg count.
- `out_chunks`  out  clog2(CHUNKS+1)  slices consumed for this result.
- `busy`  out  1  high in RUN.

Clock is single; reset is asynchronous and active-low.

## Operation
- FSM states:
  - IDLE: `in_ready`=1. On accept, register `in_pos`/`in_neg`, clear the accumulators, set idx=0, go to RUN.
  - RUN: each cycle, slice idx is `pos[2idx+1:2idx]` and `neg[4idx+3:4idx]`. Add the exact count of ones in each part to the matching accumulator and increment idx.
    - After slice CHUNKS-1, or after an early decision (see Configuration), latch the result and counts and go to DONE.
  - DONE: `out_valid`=1, with outputs held stable until `out_ready`. On handshake, go to IDLE.
- `in_ready` = (IDLE) or (DONE and `out_ready`). A simultaneous result handshake and new accept in DONE goes directly to RUN with fresh captures and cleared accumulators.
- Comparison: both counts are zero-extended to a common width and compared unsigned. Equality yields 1.
- `in_pos`/`in_neg` are ignored outside an accept cycle. Changes during RUN have no effect.
- Counts are exact. Accumulators cannot overflow at the given widths.
- Reset, including mid-RUN or mid-DONE, immediately:
  - sets the state to IDLE;
  - clears the accumulators and idx;
  - clears `out_valid`, `out_result`, `out_pos_cnt`, `out_neg_cnt` and `out_chunks` to 0.
  - Any in-flight request is dropped.
- Reset values: `in_ready`=1, `busy`=0, all other outputs 0.

## Timing
- Accept at edge T. Slices are processed in cycles T..T+CHUNKS-1, and `out_valid` rises after edge T+CHUNKS. Latency is CHUNKS cycles without early exit.
- With early exit after k slices, `out_valid` rises after edge T+k and `out_chunks`=k.
- `out_*` are registered. `in_ready` is combinational from state and `out_ready` only.
- Peak throughput is one result per CHUNKS+1 cycles, using back-to-back handoff in DONE.
- Back-pressure: DONE holds indefinitely while `out_ready`=0. `in_ready` stays low during that time unless `out_ready` rises.

## Configuration
- `PCC_SEQ_EARLY_EXIT_EN` defined: after each RUN slice, let r = remaining slices and P, N = the updated accumulators.
  - If P ≥ N + 4r, finish with result 1.
  - If P + 2r < N, finish with result 0.
  - Reported counts are the partial accumulators. `out_chunks` is the number of slices consumed.
- Not defined: always CHUNKS slices, `out_chunks`=CHUNKS, and the decision logic is absent.

## Structure
- Package `pcc_seq_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - `POS_SLICE_W`=2 and `NEG_SLICE_W`=4;
  - functions for count widths from CHUNKS.
- One sub-module, `pcc_slice_cnt`: combinational exact popcount of a 2-bit and a 4-bit slice, producing 2-bit and 3-bit counts. Instantiated once.

## Test plan
All cases use CHUNKS=4.
- Equal counts: pos=8'hFF, neg=16'h00FF → result 1, counts 8/8, `out_valid` 4 cycles after accept, `out_chunks`=4 (both configs).
- Neg-heavy: pos=8'h00, neg=16'hFFFF → result 0, counts 0/16 without macro. With macro: exit after 2 slices, counts 0/8, `out_chunks`=2.
- Pos-heavy: pos=8'hFF, neg=16'h0000 → result 1. With macro: exit after 3 slices, counts 6/0. Without macro: counts 8/0, 4 slices.
- Edge equality: pos=8'h01, neg=16'h0001 → 1. pos=0, neg=0 → 1. pos=8'h00, neg=16'h0001 → 0.
- Back-pressure/handoff: hold `out_ready`=0 for 5 cycles.
  - Outputs stay stable and `in_ready`=0 throughout.
  - Then assert `out_ready` and `in_valid` together → both handshakes complete in the same cycle, and the next result is correct with no count carry-over.
- Reset mid-RUN: deassert `rst_n` at slice 2 → `out_valid`=0, `busy`=0, `in_ready`=1 after release. The next request yields correct counts from zero.

Source files
------------

// File: rtl/pcc_seq_pkg.sv
// Shared types and width helpers for the pcc_seq popcount-compare sequencer.
package pcc_seq_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int POS_SLICE_W = 2;
  localparam int NEG_SLICE_W = 4;

  function automatic int pos_cnt_w(input int chunks);
    return $clog2(POS_SLICE_W * chunks + 1);
  endfunction

  function automatic int neg_cnt_w(input int chunks);
    return $clog2(NEG_SLICE_W * chunks + 1);
  endfunction

  function automatic int chunk_w(input int chunks);
    return $clog2(chunks + 1);
  endfunction

endpackage

// File: rtl/pcc_seq_if.sv
// Request/result handshake bundle between a vector source and pcc_seq.
interface pcc_seq_if
  import pcc_seq_pkg::*;
#(
  parameter int CHUNKS = 4
) ();

  localparam int PW  = POS_SLICE_W * CHUNKS;
  localparam int NW  = NEG_SLICE_W * CHUNKS;
  localparam int PCW = pos_cnt_w(CHUNKS);
  localparam int NCW = neg_cnt_w(CHUNKS);
  localparam int CW  = chunk_w(CHUNKS);

  logic           in_valid;
  logic           in_ready;
  logic [PW-1:0]  in_pos;
  logic [NW-1:0]  in_neg;
  logic           out_valid;
  logic           out_ready;
  logic           out_result;
  logic [PCW-1:0] out_pos_cnt;
  logic [NCW-1:0] out_neg_cnt;
  logic [CW-1:0]  out_chunks;
  logic           busy;

  modport master (
    output in_valid, in_pos, in_neg, out_ready,
    input  in_ready, out_valid, out_result, out_pos_cnt, out_neg_cnt, out_chunks, busy
  );

  modport slave (
    input  in_valid, in_pos, in_neg, out_ready,
    output in_ready, out_valid, out_result, out_pos_cnt, out_neg_cnt, out_chunks, busy
  );

endinterface

// File: rtl/pcc_slice_cnt.sv
// Exact popcount of one 2-bit pos slice and one 4-bit neg slice (combinational).
module pcc_slice_cnt
  import pcc_seq_pkg::*;
(
  input  logic [POS_SLICE_W-1:0] pos_slice,
  input  logic [NEG_SLICE_W-1:0] neg_slice,
  output logic [1:0]             pos_cnt,
  output logic [2:0]             neg_cnt
);

  assign pos_cnt = 2'(pos_slice[0]) + 2'(pos_slice[1]);
  assign neg_cnt = 3'(neg_slice[0]) + 3'(neg_slice[1]) + 3'(neg_slice[2]) + 3'(neg_slice[3]);

endmodule

// File: rtl/pcc_seq.sv
// Popcount-compare sequencer: streams captured pos/neg vectors through one slice counter.
// Optional early decision when PCC_SEQ_EARLY_EXIT_EN is defined.
module pcc_seq
  import pcc_seq_pkg::*;
#(
  parameter int CHUNKS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  pcc_seq_if.slave    bus
);

  localparam int PW     = POS_SLICE_W * CHUNKS;
  localparam int NW     = NEG_SLICE_W * CHUNKS;
  localparam int PCW    = pos_cnt_w(CHUNKS);
  localparam int NCW    = neg_cnt_w(CHUNKS);
  localparam int CW     = chunk_w(CHUNKS);
  localparam int CMP_W  = NCW;

  state_t         state_q, state_d;
  logic [CW-1:0]  idx_q, idx_d;
  logic [PCW-1:0] pacc_q, pacc_d;
  logic [NCW-1:0] nacc_q, nacc_d;
  logic [PW-1:0]  pos_q, pos_d;
  logic [NW-1:0]  neg_q, neg_d;
  logic           ov_q, ov_d;
  logic           res_q, res_d;
  logic [PCW-1:0] opc_q, opc_d;
  logic [NCW-1:0] onc_q, onc_d;
  logic [CW-1:0]  och_q, och_d;

  logic [PW-1:0]  pos_sh;
  logic [NW-1:0]  neg_sh;
  logic [1:0]     slice_pc;
  logic [2:0]     slice_nc;
  logic [PCW-1:0] p_new;
  logic [NCW-1:0] n_new;
  logic           last, accept, finish, fin_res;
`ifdef PCC_SEQ_EARLY_EXIT_EN
  logic [31:0]    rem, p32, n32;
  logic           exit_hi, exit_lo;
`endif

  assign pos_sh = pos_q >> {idx_q, 1'b0};
  assign neg_sh = neg_q >> {idx_q, 2'b00};

  pcc_slice_cnt u_slice (
    .pos_slice (pos_sh[POS_SLICE_W-1:0]),
    .neg_slice (neg_sh[NEG_SLICE_W-1:0]),
    .pos_cnt   (slice_pc),
    .neg_cnt   (slice_nc)
  );

  assign bus.in_ready    = (state_q == IDLE) || ((state_q == DONE) && bus.out_ready);
  assign bus.busy        = (state_q == RUN);
  assign bus.out_valid   = ov_q;
  assign bus.out_result  = res_q;
  assign bus.out_pos_cnt = opc_q;
  assign bus.out_neg_cnt = onc_q;
  assign bus.out_chunks  = och_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pacc_d  = pacc_q;
    nacc_d  = nacc_q;
    pos_d   = pos_q;
    neg_d   = neg_q;
    ov_d    = ov_q;
    res_d   = res_q;
    opc_d   = opc_q;
    onc_d   = onc_q;
    och_d   = och_q;
    accept  = 1'b0;
    finish  = 1'b0;
    fin_res = 1'b0;

    p_new = pacc_q + PCW'(slice_pc);
    n_new = nacc_q + NCW'(slice_nc);
    last  = (idx_q == CW'(CHUNKS - 1));
`ifdef PCC_SEQ_EARLY_EXIT_EN
    // r counts the slices still unprocessed after this one.
    rem     = 32'(CHUNKS - 1) - 32'(idx_q);
    p32     = 32'(p_new);
    n32     = 32'(n_new);
    exit_hi = p32 >= (n32 + 32'(NEG_SLICE_W) * rem);
    exit_lo = (p32 + 32'(POS_SLICE_W) * rem) < n32;
`endif

    case (state_q)
      IDLE: accept = bus.in_valid;
      RUN: begin
        pacc_d = p_new;
        nacc_d = n_new;
        idx_d  = idx_q + CW'(1);
`ifdef PCC_SEQ_EARLY_EXIT_EN
        if (exit_hi) begin
          finish  = 1'b1;
          fin_res = 1'b1;
        end else if (exit_lo || last) begin
          finish  = 1'b1;
          fin_res = CMP_W'(p_new) >= CMP_W'(n_new);
        end
`else
        if (last) begin
          finish  = 1'b1;
          fin_res = CMP_W'(p_new) >= CMP_W'(n_new);
        end
`endif
        if (finish) begin
          state_d = DONE;
          ov_d    = 1'b1;
          res_d   = fin_res;
          opc_d   = p_new;
          onc_d   = n_new;
          och_d   = idx_q + CW'(1);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
          accept  = bus.in_valid;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new capture overrides whatever the state branch chose.
    if (accept) begin
      state_d = RUN;
      pos_d   = bus.in_pos;
      neg_d   = bus.in_neg;
      pacc_d  = '0;
      nacc_d  = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pacc_q  <= '0;
      nacc_q  <= '0;
      ov_q    <= 1'b0;
      res_q   <= 1'b0;
      opc_q   <= '0;
      onc_q   <= '0;
      och_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pacc_q  <= pacc_d;
      nacc_q  <= nacc_d;
      ov_q    <= ov_d;
      res_q   <= res_d;
      opc_q   <= opc_d;
      onc_q   <= onc_d;
      och_q   <= och_d;
    end
  end

  // Captured vectors are pure data and need no reset.
  always_ff @(posedge clk) begin
    pos_q <= pos_d;
    neg_q <= neg_d;
  end

endmodule

// File: tb/tb_pcc_seq.sv
// Self-checking bench for pcc_seq (CHUNKS=4) against a slice-level reference model.
module tb_pcc_seq;

  localparam int CHUNKS = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pcc_seq_if #(.CHUNKS(CHUNKS)) bus ();

  pcc_seq #(.CHUNKS(CHUNKS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int errors = 0;
  int checks = 0;
  int mp, mn, mc, mr;
  logic [7:0]  vp, vp2;
  logic [15:0] vn, vn2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk slices in order, count ones, apply the decision rules.
  task automatic model(input logic [7:0] p, input logic [15:0] n,
                       output int ep, output int en, output int ec, output int er);
    bit stop;
    ep = 0; en = 0; ec = CHUNKS; er = 0; stop = 0;
    for (int k = 0; k < CHUNKS; k++) begin
      if (!stop) begin
        ep += $countones(p[2*k +: 2]);
        en += $countones(n[4*k +: 4]);
`ifdef PCC_SEQ_EARLY_EXIT_EN
        if (ep >= en + 4 * (CHUNKS - 1 - k)) begin
          stop = 1; ec = k + 1; er = 1;
        end else if (ep + 2 * (CHUNKS - 1 - k) < en) begin
          stop = 1; ec = k + 1; er = 0;
        end
`endif
      end
    end
    if (!stop) er = (ep >= en) ? 1 : 0;
  endtask

  task automatic accept(input logic [7:0] p, input logic [15:0] n, input string tag);
    bus.in_valid = 1'b1;
    bus.in_pos   = p;
    bus.in_neg   = n;
    #1;
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_pos   = 8'($urandom);
    bus.in_neg   = 16'($urandom);
  endtask

  task automatic check_outputs(input int ep, input int en, input int ec, input int er, input string tag);
    chk({tag, ".valid"},  32'(bus.out_valid),   32'd1);
    chk({tag, ".result"}, 32'(bus.out_result),  32'(er));
    chk({tag, ".pos"},    32'(bus.out_pos_cnt), 32'(ep));
    chk({tag, ".neg"},    32'(bus.out_neg_cnt), 32'(en));
    chk({tag, ".chunks"}, 32'(bus.out_chunks),  32'(ec));
    chk({tag, ".busy"},   32'(bus.busy),        32'd0);
  endtask

  task automatic wait_result(input logic [7:0] p, input logic [15:0] n, input string tag);
    int ep, en, ec, er, cyc;
    model(p, n, ep, en, ec, er);
    chk({tag, ".run_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".run_rdy"},  32'(bus.in_ready), 32'd0);
    cyc = 0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, 32'(cyc), 32'(ec));
    check_outputs(ep, en, ec, er, tag);
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, ".cleared"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_req(input logic [7:0] p, input logic [15:0] n, input string tag);
    accept(p, n, tag);
    wait_result(p, n, tag);
    consume(tag);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_pos   = '0;
    bus.in_neg   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", 32'(bus.in_ready),    32'd1);
    chk("rst.busy",     32'(bus.busy),        32'd0);
    chk("rst.valid",    32'(bus.out_valid),   32'd0);
    chk("rst.result",   32'(bus.out_result),  32'd0);
    chk("rst.pos",      32'(bus.out_pos_cnt), 32'd0);
    chk("rst.neg",      32'(bus.out_neg_cnt), 32'd0);
    chk("rst.chunks",   32'(bus.out_chunks),  32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Equal counts must report 1 with 8/8 after all four slices in either build.
    accept(8'hFF, 16'h00FF, "eq");
    wait_result(8'hFF, 16'h00FF, "eq");
    chk("eq.const_res", 32'(bus.out_result),  32'd1);
    chk("eq.const_pos", 32'(bus.out_pos_cnt), 32'd8);
    chk("eq.const_neg", 32'(bus.out_neg_cnt), 32'd8);
    chk("eq.const_ch",  32'(bus.out_chunks),  32'd4);
    consume("eq");

    run_req(8'h00, 16'hFFFF, "negheavy");
    run_req(8'hFF, 16'h0000, "posheavy");
    run_req(8'h01, 16'h0001, "edge_eq1");
    run_req(8'h00, 16'h0000, "edge_zero");
    run_req(8'h00, 16'h0001, "edge_lt");

    for (int i = 0; i < 24; i++) begin
      vp = 8'($urandom);
      vn = 16'($urandom);
      run_req(vp, vn, "rand");
    end

    // Back-pressure, then simultaneous result/request handshake.
    vp = 8'h5A; vn = 16'h1234;
    vp2 = 8'hC3; vn2 = 16'hF00F;
    accept(vp, vn, "bp");
    wait_result(vp, vn, "bp");
    model(vp, vn, mp, mn, mc, mr);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp.hold_rdy", 32'(bus.in_ready), 32'd0);
      check_outputs(mp, mn, mc, mr, "bp.hold");
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_pos    = vp2;
    bus.in_neg    = vn2;
    #1;
    chk("bp.handoff_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_pos    = 8'hFF;
    bus.in_neg    = 16'h0000;
    chk("bp.handoff_valid", 32'(bus.out_valid), 32'd0);
    wait_result(vp2, vn2, "bp2");
    consume("bp2");

    // Reset while slice 2 is in progress.
    accept(8'hFF, 16'hFFFF, "rstrun");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstrun.valid", 32'(bus.out_valid),   32'd0);
    chk("rstrun.busy",  32'(bus.busy),        32'd0);
    chk("rstrun.rdy",   32'(bus.in_ready),    32'd1);
    chk("rstrun.pos",   32'(bus.out_pos_cnt), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstrun.post_rdy",   32'(bus.in_ready),  32'd1);
    chk("rstrun.post_valid", 32'(bus.out_valid), 32'd0);
    run_req(8'h0F, 16'h00F0, "after_rst");

    // Reset while a result is waiting.
    accept(8'hFF, 16'h0000, "rstdone");
    wait_result(8'hFF, 16'h0000, "rstdone");
    rst_n = 1'b0;
    #1;
    chk("rstdone.valid",  32'(bus.out_valid),  32'd0);
    chk("rstdone.result", 32'(bus.out_result), 32'd0);
    chk("rstdone.chunks", 32'(bus.out_chunks), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_req(8'h33, 16'h0F0F, "after_rst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
